// File: rtl/tff_sync_counter_pkg.sv
// Shared definitions for the toggle-cell modulo counter: direction encoding and
// default geometry.
package tff_sync_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_MOD   = 10;

endpackage

// File: rtl/tff_sync_counter_if.sv
// Control/observation bundle of the modulo counter; the master drives commands,
// the counter (slave) returns state, toggle vector and terminal count.
interface tff_sync_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t_vec;
  logic             tc;

  modport master (
    output en, up, load, d,
    input  q, t_vec, tc
  );

  modport slave (
    input  en, up, load, d,
    output q, t_vec, tc
  );
endinterface

// File: rtl/tff_sync_counter_cell.sv
// Single T flip-flop: toggles on a rising edge when t is high, cleared
// asynchronously by rst_n.
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else if (t) begin
      q_q <= ~q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tff_sync_counter.sv
// Modulo-MOD up/down counter with clamped parallel load; the next state is
// converted to a per-bit toggle vector that drives a bank of T cells.
module tff_sync_counter
  import tff_sync_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MOD   = DEFAULT_MOD
) (
  input  logic                clk,
  input  logic                rst_n,
  tff_sync_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD - 1);
  // One extra bit so MOD == 2^WIDTH compares correctly (clamp never fires).
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] t_vec;
  logic             at_last;
  logic             at_zero;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return ({1'b0, v} >= MOD_EXT) ? LAST : v;
  endfunction

  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
    return (v == LAST) ? '0 : v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
    return (v == '0) ? LAST : v - WIDTH'(1);
  endfunction

  assign at_last = (q_q == LAST);
  assign at_zero = (q_q == '0);

  always_comb begin
    cnt_d = q_q;
    if (bus.load) begin
      cnt_d = clamp_load(bus.d);
    end else if (bus.en) begin
      cnt_d = (bus.up == DIR_UP) ? step_up(q_q) : step_down(q_q);
    end
  end

  assign t_vec = q_q ^ cnt_d;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (t_vec[i]),
        .q     (q_q[i])
      );
    end
  endgenerate

  assign bus.q     = q_q;
  assign bus.t_vec = t_vec;
  assign bus.tc    = bus.en & ~bus.load &
                     (((bus.up == DIR_UP)   & at_last) |
                      ((bus.up == DIR_DOWN) & at_zero));

endmodule

// File: tb/tb_tff_sync_counter.sv
// Scoreboard bench for tff_sync_counter (WIDTH=4, MOD=10): directed scenarios
// followed by random commands, compared against an arithmetic reference model.
module tb_tff_sync_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  typedef struct {
    int q;
    int t;
    bit tc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tff_sync_counter_if #(.WIDTH(W)) bus ();

  tff_sync_counter #(.WIDTH(W), .MOD(MOD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   mq = 0;

  function automatic int ref_next(int q, bit en, bit up, bit load, int d);
    if (load) return (d >= MOD) ? MOD - 1 : d;
    if (en)   return up ? (q + 1) % MOD : (q + MOD - 1) % MOD;
    return q;
  endfunction

  function automatic bit ref_tc(int q, bit en, bit up, bit load);
    return en && !load && ((up && q + 1 == MOD) || (!up && q == 0));
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of commands at the falling edge and queue what the DUT must show.
  task automatic step(input bit rst, input bit en, input bit up, input bit load, input int d);
    exp_t e;
    bit   was_running;
    @(negedge clk);
    was_running = rst_n;
    rst_n    = rst;
    bus.en   = en;
    bus.up   = up;
    bus.load = load;
    bus.d    = W'(d);
    if (!rst) mq = 0;
    e.q  = mq;
    e.t  = mq ^ ref_next(mq, en, up, load, d);
    e.tc = ref_tc(mq, en, up, load);
    exp_q.push_back(e);
    if (was_running && !rst) begin
      #1;
      check("async_reset_q", int'(bus.q), 0);
    end
    if (rst) mq = ref_next(mq, en, up, load, d);
  endtask

  // Monitor: sample mid-cycle, compare against the oldest queued expectation.
  initial begin : monitor
    int  prev_q;
    int  prev_t;
    bit  prev_rst;
    exp_t e;
    prev_q = 0;
    prev_t = 0;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("q", int'(bus.q), e.q);
        check("t_vec", int'(bus.t_vec), e.t);
        check("tc", int'(bus.tc), int'(e.tc));
        check("q_in_range", int'(bus.q < W'(MOD)), 1);
        if (prev_rst && rst_n) check("q_eq_prev_q_xor_t", int'(bus.q), prev_q ^ prev_t);
        prev_q   = int'(bus.q);
        prev_t   = int'(bus.t_vec);
        prev_rst = rst_n;
      end
    end
  end

  initial begin
    bus.en = 1'b0;
    bus.up = 1'b1;
    bus.load = 1'b0;
    bus.d = '0;

    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    // Count up from zero through the wrap.
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 7);
    // Reset mid-count while commanded to count down.
    step(0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    // Down wrap from 1.
    step(1, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    // Load priority and clamp.
    step(1, 1, 1, 1, 6);
    step(1, 1, 0, 1, 13);
    step(1, 0, 0, 1, 15);
    // Hold then direction flips.
    step(1, 0, 1, 1, 4);
    for (int i = 0; i < 5; i++) step(1, 0, $urandom_range(0, 1), 0, $urandom_range(0, 15));
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    // Random commands.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1),
           ($urandom_range(0, 7) == 0),
           $urandom_range(0, 15));
    end
    step(1, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    #5;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
